// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the one-shot timer register port and
//                the periodic re-arm controller that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Timer register indices on the addr/wr/select/data bus
    localparam logic [1:0] REG_TIMERCNT = 2'd0;
    localparam logic [1:0] REG_TIMERVAL = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;

    // STATUS register bit positions
    localparam int STATUS_IRQ_BIT = 0;  // read: irq pending, write: reset timer
    localparam int STATUS_EN_BIT  = 1;  // enable

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_VAL = 3'd1,
        ST_ARM    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DISARM = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_rearm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_rearm_ctrl_if
//  Description : Timer register port (addr/wr/select/data). The initiator
//                uses the master modport, the timer uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_rearm_ctrl_if;

    logic [1:0]  bus_addr;
    logic [3:0]  bus_wr;
    logic        bus_select;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wr,
        output bus_select,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wr,
        input  bus_select,
        input  bus_wdata,
        output bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/timer_rearm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timer_rearm_ctrl
//  Description : Turns a one-shot timer into a periodic tick source. Programs
//                the compare value, arms the timer, waits for its interrupt,
//                confirms it through a STATUS read, pulses tick and re-arms.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_rearm_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int SPUR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_counter,
    input  logic [31:0]          cfg_period,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 timer_irq,
    timer_rearm_ctrl_if.master   bus,
    output logic                 tick,
    output logic [CNT_W-1:0]     tick_count,
    output logic [SPUR_W-1:0]    spurious_count,
    output logic                 running
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_period;
    logic [31:0]         w_period_sel;
    logic                w_confirm;
    logic                w_spurious;
    logic                r_tick;
    logic [CNT_W-1:0]    r_tick_count;
    logic [SPUR_W-1:0]   r_spurious_count;
    logic                r_running;
    logic [1:0]          r_addr;
    logic [3:0]          r_wr;
    logic                r_select;
    logic [31:0]         r_wdata;

    // A zero compare value would never expire, so it is promoted to 1
    assign w_period_sel = (cfg_period == 32'd0) ? 32'd1 : cfg_period;

    // STATUS is read combinationally while CHECK is on the bus
    assign w_confirm  = (r_state == ST_CHECK) &&  bus.bus_rdata[STATUS_IRQ_BIT];
    assign w_spurious = (r_state == ST_CHECK) && !bus.bus_rdata[STATUS_IRQ_BIT];

    // Next-state selection; stop overrides every transition outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = cfg_start ? ST_WR_VAL : ST_IDLE;
            ST_WR_VAL: w_state_nxt = ST_ARM;
            ST_ARM:    w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_WAIT;
            ST_WAIT:   w_state_nxt = timer_irq ? ST_CHECK : ST_WAIT;
            ST_CHECK:  w_state_nxt = w_confirm ? ST_ARM : ST_WAIT;
            ST_DISARM: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (cfg_stop && (r_state != ST_IDLE) && (r_state != ST_DISARM)) begin
            w_state_nxt = ST_DISARM;
        end
    end

    // State, counters and registered bus drive for the state being entered
    always_ff @(posedge clk or posedge rst_counter) begin
        if (rst_counter) begin
            r_state          <= ST_IDLE;
            r_period         <= 32'd0;
            r_tick           <= 1'b0;
            r_tick_count     <= '0;
            r_spurious_count <= '0;
            r_running        <= 1'b0;
            r_addr           <= 2'd0;
            r_wr             <= 4'h0;
            r_select         <= 1'b0;
            r_wdata          <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt != ST_IDLE);
            r_tick    <= w_confirm;

            if ((r_state == ST_IDLE) && cfg_start) begin
                r_period     <= w_period_sel;
                r_tick_count <= '0;
            end else if (w_confirm) begin
                r_tick_count <= r_tick_count + 1'b1;
            end

            if (w_spurious && (r_spurious_count != {SPUR_W{1'b1}})) begin
                r_spurious_count <= r_spurious_count + 1'b1;
            end

            r_addr   <= 2'd0;
            r_wr     <= 4'h0;
            r_select <= 1'b0;
            r_wdata  <= 32'd0;
            case (w_state_nxt)
                ST_WR_VAL: begin
                    // Only reachable from IDLE, where the period is latched now
                    r_addr   <= REG_TIMERVAL;
                    r_wr     <= 4'hF;
                    r_select <= 1'b1;
                    r_wdata  <= w_period_sel;
                end
                ST_ARM: begin
                    r_addr   <= REG_STATUS;
                    r_wr     <= 4'h1;
                    r_select <= 1'b1;
                    r_wdata  <= 32'h3;
                end
                ST_CHECK: begin
                    r_addr   <= REG_STATUS;
                    r_select <= 1'b1;
                end
                ST_DISARM: begin
                    r_addr   <= REG_STATUS;
                    r_wr     <= 4'h1;
                    r_select <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign tick           = r_tick;
    assign tick_count     = r_tick_count;
    assign spurious_count = r_spurious_count;
    assign running        = r_running;
    assign bus.bus_addr   = r_addr;
    assign bus.bus_wr     = r_wr;
    assign bus.bus_select = r_select;
    assign bus.bus_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_rearm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_rearm_ctrl
//  Description : Directed self-checking bench for timer_rearm_ctrl with a
//                behavioural one-shot timer on the register port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_rearm_ctrl;

    logic        clk = 1'b0;
    logic        rst_counter;
    logic [31:0] cfg_period;
    logic        cfg_start;
    logic        cfg_stop;
    logic        timer_irq;
    logic        tick;
    logic [31:0] tick_count;
    logic [7:0]  spurious_count;
    logic        running;
    logic        force_irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Timer model state
    logic [31:0] m_cnt;
    logic [31:0] m_val;
    logic        m_en;
    logic        m_flag;

    timer_rearm_ctrl_if bus_if ();

    timer_rearm_ctrl #(.CNT_W(32), .SPUR_W(8)) dut (
        .clk            (clk),
        .rst_counter    (rst_counter),
        .cfg_period     (cfg_period),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .timer_irq      (timer_irq),
        .bus            (bus_if),
        .tick           (tick),
        .tick_count     (tick_count),
        .spurious_count (spurious_count),
        .running        (running)
    );

    always #5 clk = ~clk;

    // Cycle index; at a falling edge it names the cycle being observed
    always @(posedge clk) cyc <= cyc + 1;

    // One-shot timer: STATUS write bit0 resets, bit1 enables; flag sets once
    // the count passes the compare value
    always @(posedge clk or posedge rst_counter) begin
        if (rst_counter) begin
            m_cnt <= 0; m_val <= 0; m_en <= 1'b0; m_flag <= 1'b0;
        end else if (bus_if.bus_select && (bus_if.bus_wr != 4'h0)) begin
            if (bus_if.bus_addr == 2'd1) m_val <= bus_if.bus_wdata;
            if (bus_if.bus_addr == 2'd2) begin
                if (bus_if.bus_wdata[0]) begin
                    m_cnt  <= 0;
                    m_flag <= 1'b0;
                end
                m_en <= bus_if.bus_wdata[1];
            end
        end else if (m_en) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 > m_val) m_flag <= 1'b1;
        end
    end

    assign timer_irq = m_flag | force_irq;
    assign bus_if.bus_rdata = (bus_if.bus_addr == 2'd2) ? {30'd0, m_en, m_flag} :
                              (bus_if.bus_addr == 2'd1) ? m_val : m_cnt;

    task automatic do_start(input logic [31:0] p);
        cfg_period = p;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    task automatic do_stop();
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        for (int i = 0; i < 5 && running; i++) @(negedge clk);
    endtask

    // Returns the cycle of the next tick, or -1 once the budget runs out
    task automatic wait_tick(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_counter = 1'b1; cfg_period = 0; cfg_start = 0; cfg_stop = 0; force_irq = 0;
        repeat (3) @(negedge clk);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", tick); end
        checks++; if (tick_count !== 32'd0) begin errors++; $display("FAIL reset_tick_count: got %0d want 0", tick_count); end
        checks++; if (spurious_count !== 8'd0) begin errors++; $display("FAIL reset_spurious: got %0d want 0", spurious_count); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", running); end
        checks++;
        if ({bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata} !== 39'd0) begin
            errors++; $display("FAIL reset_bus: sel=%0b addr=%0d wr=%h wdata=%h want all 0",
                bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        rst_counter = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_period10();
        int t_arm, t_prev, t;
        do_start(32'd10);
        checks++;
        if (bus_if.bus_select !== 1'b1 || bus_if.bus_addr !== 2'd1 || bus_if.bus_wr !== 4'hF || bus_if.bus_wdata !== 32'd10) begin
            errors++; $display("FAIL p10_wr_val: sel=%0b addr=%0d wr=%h wdata=%0d want 1/1/F/10",
                bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        @(negedge clk);
        t_arm = cyc;
        checks++;
        if (bus_if.bus_select !== 1'b1 || bus_if.bus_addr !== 2'd2 || bus_if.bus_wr !== 4'h1 || bus_if.bus_wdata !== 32'h3) begin
            errors++; $display("FAIL p10_arm: sel=%0b addr=%0d wr=%h wdata=%h want 1/2/1/3",
                bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL p10_running: got %0b want 1", running); end
        wait_tick(60, t);
        checks++; if (t - t_arm != 14) begin errors++; $display("FAIL p10_first_tick: got %0d cycles want 14", t - t_arm); end
        checks++;
        if (bus_if.bus_addr !== 2'd2 || bus_if.bus_wr !== 4'h1 || bus_if.bus_wdata !== 32'h3) begin
            errors++; $display("FAIL p10_tick_with_rearm: addr=%0d wr=%h wdata=%h want 2/1/3",
                bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        checks++; if (tick_count !== 32'd1) begin errors++; $display("FAIL p10_count1: got %0d want 1", tick_count); end
        for (int k = 2; k <= 5; k++) begin
            t_prev = t;
            wait_tick(60, t);
            checks++; if (t - t_prev != 14) begin errors++; $display("FAIL p10_spacing%0d: got %0d want 14", k, t - t_prev); end
        end
        checks++; if (tick_count !== 32'd5) begin errors++; $display("FAIL p10_count5: got %0d want 5", tick_count); end
        @(negedge clk);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL p10_tick_width: got %0b want 0", tick); end
        do_stop();
    endtask

    task automatic test_period0();
        int t_prev, t;
        do_start(32'd0);
        checks++; if (bus_if.bus_wdata !== 32'd1 || bus_if.bus_addr !== 2'd1) begin
            errors++; $display("FAIL p0_wr_val: addr=%0d wdata=%0d want 1/1", bus_if.bus_addr, bus_if.bus_wdata);
        end
        @(negedge clk);
        t = cyc;
        for (int k = 1; k <= 3; k++) begin
            t_prev = t;
            wait_tick(30, t);
            checks++; if (t - t_prev != 5) begin errors++; $display("FAIL p0_spacing%0d: got %0d want 5", k, t - t_prev); end
        end
        do_stop();
    endtask

    task automatic test_spurious();
        bit seen;
        do_start(32'd200);
        @(negedge clk);
        repeat (4) @(negedge clk);
        force_irq = 1'b1;
        @(negedge clk);
        force_irq = 1'b0;
        checks++;
        if (bus_if.bus_select !== 1'b1 || bus_if.bus_addr !== 2'd2 || bus_if.bus_wr !== 4'h0) begin
            errors++; $display("FAIL spur_check_read: sel=%0b addr=%0d wr=%h want 1/2/0",
                bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr);
        end
        @(negedge clk);
        checks++; if (spurious_count !== 8'd1) begin errors++; $display("FAIL spur_count: got %0d want 1", spurious_count); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL spur_no_tick: got %0b want 0", tick); end
        checks++; if (bus_if.bus_select !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL spur_back_wait: sel=%0b running=%0b want 0/1", bus_if.bus_select, running);
        end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (tick) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL spur_quiet: got tick want none"); end
        do_stop();
    endtask

    task automatic test_start_ignored();
        int t1, t2, t3;
        do_start(32'd10);
        @(negedge clk);
        wait_tick(60, t1);
        @(negedge clk);
        cfg_period = 32'd4;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
        wait_tick(60, t2);
        checks++; if (t2 - t1 != 14) begin errors++; $display("FAIL ign_spacing1: got %0d want 14", t2 - t1); end
        wait_tick(60, t3);
        checks++; if (t3 - t2 != 14) begin errors++; $display("FAIL ign_spacing2: got %0d want 14", t3 - t2); end
        do_stop();
    endtask

    task automatic test_stop_in_wait();
        int t;
        bit seen;
        do_start(32'd10);
        @(negedge clk);
        wait_tick(60, t);
        @(negedge clk);   // SETTLE
        @(negedge clk);   // WAIT
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        checks++;
        if (bus_if.bus_select !== 1'b1 || bus_if.bus_addr !== 2'd2 || bus_if.bus_wr !== 4'h1 || bus_if.bus_wdata !== 32'd0) begin
            errors++; $display("FAIL stop_disarm: sel=%0b addr=%0d wr=%h wdata=%h want 1/2/1/0",
                bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL stop_running_disarm: got %0b want 1", running); end
        @(negedge clk);
        checks++; if (running !== 1'b0 || bus_if.bus_select !== 1'b0) begin
            errors++; $display("FAIL stop_idle: running=%0b sel=%0b want 0/0", running, bus_if.bus_select);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (tick) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL stop_no_ticks: got tick want none"); end
    endtask

    task automatic test_reset_mid();
        int t, t_arm;
        do_start(32'd3);
        @(negedge clk);
        repeat (3) wait_tick(30, t);
        checks++; if (tick_count !== 32'd3) begin errors++; $display("FAIL rmid_count3: got %0d want 3", tick_count); end
        @(negedge clk);
        @(negedge clk);
        #2 rst_counter = 1'b1;
        #1;
        checks++;
        if (tick !== 1'b0 || tick_count !== 32'd0 || spurious_count !== 8'd0 || running !== 1'b0 ||
            bus_if.bus_select !== 1'b0 || bus_if.bus_addr !== 2'd0 || bus_if.bus_wr !== 4'h0 || bus_if.bus_wdata !== 32'd0) begin
            errors++; $display("FAIL rmid_async: tick=%0b cnt=%0d spur=%0d run=%0b sel=%0b addr=%0d wr=%h wdata=%h want all 0",
                tick, tick_count, spurious_count, running, bus_if.bus_select, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_wdata);
        end
        @(negedge clk);
        rst_counter = 1'b0;
        @(negedge clk);
        do_start(32'd3);
        checks++; if (tick_count !== 32'd0 || bus_if.bus_wdata !== 32'd3) begin
            errors++; $display("FAIL rmid_restart: cnt=%0d wdata=%0d want 0/3", tick_count, bus_if.bus_wdata);
        end
        @(negedge clk);
        t_arm = cyc;
        wait_tick(30, t);
        checks++; if (t - t_arm != 7 || tick_count !== 32'd1) begin
            errors++; $display("FAIL rmid_first_tick: spacing=%0d cnt=%0d want 7/1", t - t_arm, tick_count);
        end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_period10();
        test_period0();
        test_spurious();
        test_start_ignored();
        test_stop_in_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/timer_rearm_ctrl.md
# timer_rearm_ctrl

Bus initiator that drives the one-shot timer peripheral's register port to turn it into a periodic tick source. It programs the timer's compare value, arms it, and waits for the timer interrupt. It then confirms the interrupt by reading the timer's status register, emits a one-cycle tick, and re-arms. It sits between a configuration source and the timer instance, on the initiator side of the timer's addr/wr/select/data bus.

## Interface
Parameters:
- CNT_W, 32, width of tick_count.
- SPUR_W, 8, width of spurious_count (saturating).

Ports:
- clk  in  1  clock.
- rst_counter  in  1  reset, asynchronous, active-high.
- cfg_period  in  32  timer compare value; latched on accepted cfg_start.
- cfg_start  in  1  start request; honoured only in IDLE.
- cfg_stop  in  1  stop request; honoured in any non-IDLE state.
- timer_irq  in  1  timer interrupt (level).
- bus_rdata  in  32  timer read data, combinational from bus_addr.
- bus_addr  out  2  register index (0 TIMERCNT, 1 TIMERVAL, 2 STATUS).
- bus_wr  out  4  byte write strobes.
- bus_select  out  1  timer select.
- bus_wdata  out  32  write data.
- tick  out  1  one-cycle pulse per confirmed expiry.
- tick_count  out  CNT_W  confirmed ticks since start, wraps.
- spurious_count  out  SPUR_W  irq samples not confirmed by status read; saturates at all-ones.
- running  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WR_VAL, ARM, SETTLE, WAIT, CHECK, DISARM.
- IDLE: bus idle. On cfg_start, latch period = (cfg_period == 0 ? 1 : cfg_period), clear tick_count, and go to WR_VAL.
- WR_VAL: addr=1, wr=4'hF, select=1, wdata=period. Go to ARM.
- ARM: addr=2, wr=4'h1, select=1, wdata=32'h3 (reset timer, enable). Go to SETTLE.
- SETTLE: bus idle; irq ignored. Go to WAIT.
- WAIT: bus idle. When timer_irq is sampled high, go to CHECK.
- CHECK: addr=2, wr=0, select=1; sample bus_rdata in the same cycle.
  - If bit0=1: assert tick next cycle, increment tick_count, go to ARM.
  - Else: increment spurious_count (saturating), go to WAIT.
- DISARM: addr=2, wr=4'h1, select=1, wdata=0 (disable). Go to IDLE.
- cfg_stop in any non-IDLE state: next state is DISARM, except in ARM and WR_VAL, where the current write completes first and DISARM follows.
- cfg_stop takes priority over a simultaneous tick: the tick is still emitted and counted if CHECK confirmed it.
- cfg_start in any non-IDLE state is ignored; a new period takes effect only after stop and restart.
- In idle cycles the bus drives select=0, wr=0, addr=0, wdata=0.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-transaction drops the bus to idle immediately (asynchronous).
- Start latency: cfg_start sampled at edge N; WR_VAL drives the bus in cycle N+1 and ARM in cycle N+2.
- Steady state against a conforming timer: consecutive ARM writes, and therefore consecutive tick pulses, are exactly period+4 cycles apart.
- tick is registered and asserts in the same cycle the ARM re-write is driven.
- tick_count updates in the same cycle as tick; wraps from all-ones to 0.
- Every bus transaction lasts exactly one cycle; there are no wait states.

## Structure
- Shared package timer_pkg holds:
  - Register indices REG_TIMERCNT=0, REG_TIMERVAL=1, REG_STATUS=2.
  - STATUS bit positions: bit0 irq/reset, bit1 enable.
  - The state enum.
- Single module; no sub-module. The reset name rst_counter is already fixed at the instantiation point.

## Test plan
- Start with cfg_period=10 against the timer model -> bus sequence WR_VAL(10), ARM(3); first tick 14 cycles after ARM, then ticks every 14 cycles; tick_count reaches 5 after 5 ticks.
- cfg_period=0 -> TIMERVAL written as 1; ticks every 5 cycles.
- Force timer_irq high for one cycle while the status model returns bit0=0 -> spurious_count increments by 1, no tick, FSM back in WAIT.
- Assert cfg_stop during WAIT -> next cycle DISARM writes 0 to STATUS; running drops the following cycle; no further ticks.
- Assert rst_counter mid-WAIT with tick_count=3 -> all outputs 0 immediately; a subsequent cfg_start restarts cleanly with tick_count=0.
- Assert cfg_start while running with a different period -> ignored; tick spacing unchanged.
